// File: rtl/rr_mux_stream.sv
// -----------------------------------------------------------------------------
// rr_mux_stream
//   Registered N_CH-channel, W-bit stream multiplexer. Channels are selected
//   round-robin and every channel and the output use a valid/ready handshake.
//   One beat per cycle when the consumer keeps out_ready high. Each input
//   reaches the output one cycle after it is accepted.
//
// Optional feature (compile-time macro RR_MUX_LOCK_EN):
//   Packet lock. After a beat with in_last=0 is accepted from a channel, the
//   grant stays on that channel until that channel's in_last=1 beat is
//   transferred. Without the macro, arbitration is per beat, in_last is
//   ignored and out_last is tied to 0.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous active-high reset
//   in_valid   in   N_CH     per-channel valid
//   in_data    in   N_CH*W   channel i at [i*W +: W]
//   in_last    in   N_CH     per-channel end-of-packet (lock build only)
//   in_ready   out  N_CH     per-channel ready, at most one bit set
//   out_valid  out  1        output register holds a beat
//   out_data   out  W        data of the held beat
//   out_ch     out  CH_W     source channel of the held beat
//   out_last   out  1        in_last of the held beat (0 without lock)
//   out_ready  in   1        consumer accepts the held beat
// -----------------------------------------------------------------------------
module rr_mux_stream #(
    parameter  int N_CH = 4,
    parameter  int W    = 8,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_last,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_last,
    input  logic              out_ready
);

    logic              r_out_valid;
    logic [W-1:0]      r_out_data;
    logic [CH_W-1:0]   r_out_ch;
    logic [CH_W-1:0]   r_prio;

    logic              w_load;
    logic              w_xfer;
    logic              w_gnt_vld;
    logic [CH_W-1:0]   w_gnt_idx;
    logic [CH_W-1:0]   w_gnt_nxt;
    logic [W-1:0]      w_sel_data;
    logic [2*N_CH-1:0] w_rot2;
    logic [N_CH-1:0]   w_onehot;

`ifdef RR_MUX_LOCK_EN
    logic              r_out_last;
    logic              r_lock;
    logic [CH_W-1:0]   r_lock_ch;
    logic              w_sel_last;
`else
    logic              w_unused_last;
    assign w_unused_last = ^in_last;
`endif

    // Output register is free, or its beat leaves this cycle.
    assign w_load = !r_out_valid || out_ready;

    // Rotate the valid vector so that bit 0 is the current priority channel.
    // The first set bit k then maps back to channel (prio + k) mod N_CH.
    assign w_rot2 = {in_valid, in_valid} >> r_prio;

    always_comb begin
        logic [CH_W:0] sum;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        sum       = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            // Scanning downwards: the last hit is the lowest k.
            if (w_rot2[k]) begin
                sum = {1'b0, r_prio} + (CH_W + 1)'(k);
                if (sum >= (CH_W + 1)'(N_CH))
                    sum = sum - (CH_W + 1)'(N_CH);
                w_gnt_vld = 1'b1;
                w_gnt_idx = sum[CH_W-1:0];
            end
        end
`ifdef RR_MUX_LOCK_EN
        // An open packet owns the output even while its channel is idle.
        if (r_lock) begin
            w_gnt_vld = in_valid[r_lock_ch];
            w_gnt_idx = r_lock_ch;
        end
`endif
    end

    assign w_gnt_nxt  = (w_gnt_idx == CH_W'(N_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_sel_data = in_data[w_gnt_idx*W +: W];
    assign w_onehot   = N_CH'(1) << w_gnt_idx;
    assign w_xfer     = w_load && w_gnt_vld;

    // No ready is offered while reset is held, even though load is high then.
    assign in_ready = (w_xfer && !rst) ? w_onehot : '0;

`ifdef RR_MUX_LOCK_EN
    assign w_sel_last = in_last[w_gnt_idx];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_prio      <= '0;
`ifdef RR_MUX_LOCK_EN
            r_out_last  <= 1'b0;
            r_lock      <= 1'b0;
            r_lock_ch   <= '0;
`endif
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_ch    <= w_gnt_idx;
`ifdef RR_MUX_LOCK_EN
            r_out_last  <= w_sel_last;
            if (w_sel_last) begin
                r_prio <= w_gnt_nxt;
                r_lock <= 1'b0;
            end else begin
                r_lock    <= 1'b1;
                r_lock_ch <= w_gnt_idx;
            end
`else
            r_prio      <= w_gnt_nxt;
`endif
        end else if (w_load) begin
            // Drained with nothing to replace it; data/ch keep last values.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
`ifdef RR_MUX_LOCK_EN
    assign out_last  = r_out_last;
`else
    assign out_last  = 1'b0;
`endif

endmodule
